// File: rtl/seg7_pkg.sv
// Shared types and segment tables for the 4-digit 7-segment scan driver.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

    typedef logic [4:0] digit_code_t;
    typedef logic [6:0] seg_pat_t;

    localparam digit_code_t CODE_DASH  = 5'd16;
    localparam digit_code_t CODE_BLANK = 5'd31;

    localparam seg_pat_t SEG_BLANK = 7'b1111111;
    localparam seg_pat_t SEG_DASH  = 7'b0111111;

    function automatic seg_pat_t hex_pattern(input logic [3:0] nib);
        seg_pat_t pat;
        case (nib)
            4'h0: pat = 7'b1000000;
            4'h1: pat = 7'b1111001;
            4'h2: pat = 7'b0100100;
            4'h3: pat = 7'b0110000;
            4'h4: pat = 7'b0011001;
            4'h5: pat = 7'b0010010;
            4'h6: pat = 7'b0000010;
            4'h7: pat = 7'b1111000;
            4'h8: pat = 7'b0000000;
            4'h9: pat = 7'b0010000;
            4'hA: pat = 7'b0001000;
            4'hB: pat = 7'b0000011;
            4'hC: pat = 7'b1000110;
            4'hD: pat = 7'b0100001;
            4'hE: pat = 7'b0000110;
            default: pat = 7'b0001110;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational 5-bit digit code to active-low 7-segment pattern decoder.
// Codes 0-15 are hex, 16 is a dash, 17-31 are blank.
module seg7_decode
    import seg7_pkg::*;
(
    input  digit_code_t code,
    output seg_pat_t    seg
);

    // NOTE: assign a default before any branch so the combinational block can never infer a latch.
    always_comb begin
        seg = SEG_BLANK;
        if (code < CODE_DASH) begin
            seg = hex_pattern(code[3:0]);
        end else if (code == CODE_DASH) begin
            seg = SEG_DASH;
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 4-digit common-anode display driver with per-frame snapshot
// and anti-ghost blanking. Define SEG7_BLINK_EN to enable the blink feature.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int GHOST_CYC    = 16,
    parameter int BLINK_FRAMES = 125
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] bits,
    input  logic        blink,
    output logic [7:0]  seg,
    output logic [3:0]  dig_en,
    output logic        frame_tick
);

    localparam int PW = $clog2(SCAN_DIV);

    logic [PW-1:0] presc;
    logic [1:0]    idx;
    logic [19:0]   frame;
    logic          first_f;
    logic          tick;
    logic          load;
    logic          ghost;
    logic          blank_req;
    digit_code_t   cur_code;
    seg_pat_t      cur_pat;

    assign tick  = (presc == PW'(SCAN_DIV - 1));
    assign load  = (tick && (idx == 2'd3)) || first_f;
    assign ghost = (presc < PW'(GHOST_CYC));

    always_comb begin
        cur_code = frame[19:15];
        case (idx)
            2'd0: cur_code = frame[19:15];
            2'd1: cur_code = frame[14:10];
            2'd2: cur_code = frame[9:5];
            2'd3: cur_code = frame[4:0];
        endcase
    end

    seg7_decode u_decode (
        .code (cur_code),
        .seg  (cur_pat)
    );

`ifdef SEG7_BLINK_EN
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [BW-1:0] blink_cnt;
    logic          blink_phase;

    // Phase 0 is lit, so a fresh blink request always starts visible.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (!blink) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (load) begin
            if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    assign blank_req = blink && blink_phase;
`else
    logic unused_blink;
    assign unused_blink = blink;
    assign blank_req    = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc      <= '0;
            idx        <= 2'd0;
            frame      <= 20'hFFFFF;
            first_f    <= 1'b1;
            frame_tick <= 1'b0;
            seg        <= 8'hFF;
            dig_en     <= 4'hF;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick) begin
                idx <= idx + 2'd1;
            end
            // Snapshot once per frame so a digit never mixes two input words.
            if (load) begin
                frame <= bits;
            end
            first_f    <= 1'b0;
            frame_tick <= load;
            seg        <= {1'b1, cur_pat};
            dig_en     <= (ghost || blank_req) ? 4'hF : ~(4'b0001 << idx);
        end
    end

endmodule
